uart_apb_ctrl: RTL and testbench
================================

UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

Interface
REQ-001 The block SHALL have parameters: ADDR_W, 12, APB address width; STALL_MAX, 15, max cycles a TX-data write waits on tx_full_i (1..255).
REQ-002 The block SHALL have ports, one clock and asynchronous active-low reset, exactly:
 clk_i  in  1  clock, all state rising-edge
 rst_n_i  in  1  asynchronous active-low reset
 psel_i  in  1  APB select
 penable_i  in  1  APB enable
 pwrite_i  in  1  1=write, 0=read
 paddr_i  in  ADDR_W  byte address
 pwdata_i  in  32  write data
 prdata_o  out  32  read data, valid while pready_o=1
 pready_o  out  1  transfer complete, one-cycle pulse
 pslverr_o  out  1  error response, valid while pready_o=1
 ctrl_wr_o  out  1  register-bank write strobe, one cycle
 ctrl_rd_o  out  1  register-bank read strobe, one cycle
 ctrl_addr_o  out  3  register index
 ctrl_wdata_o  out  32  register-bank write data
 ctrl_rdata_i  in  32  register-bank read data, valid one cycle after ctrl_rd_o
 tx_full_i  in  1  TX FIFO full

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, STALL, RDWAIT, RESP; all outputs registered.
REQ-004 In IDLE, psel_i=1 and penable_i=0 SHALL latch paddr_i, pwrite_i, pwdata_i and go to ISSUE.
REQ-005 Index = paddr[4:2]; access SHALL be valid only if paddr[1:0]=0, paddr[ADDR_W-1:5]=0, index<=4, not write-to-4 (RX data, read-only), not read-of-3 (TX data, write-only).
REQ-006 ISSUE, valid write, index!=3 or tx_full_i=0: ctrl_wr_o=1 for that cycle with ctrl_addr_o/ctrl_wdata_o = latched values; next RESP.
REQ-007 ISSUE, valid write to index 3 with tx_full_i=1: go to STALL, stall counter cleared to 0, no strobe.
REQ-008 STALL: each cycle counter+1; tx_full_i=0 -> go to ISSUE (push on its next cycle); counter reaching STALL_MAX with tx_full_i=1 -> RESP as error, no push.
REQ-009 ISSUE, valid read: ctrl_rd_o=1 for one cycle; next RDWAIT, where prdata_o is loaded from ctrl_rdata_i; next RESP.
REQ-010 ISSUE, invalid access: no strobe; next RESP as error; prdata_o=0.
REQ-011 RESP: pready_o=1 for exactly one cycle, pslverr_o per REQ-016; next IDLE; prdata_o held until next read RESP.
REQ-012 Latency from SETUP cycle to pready_o: write 2 cycles, read 3 cycles, stalled write 2+N+1 cycles (N stall cycles), error 2 cycles.
REQ-013 psel_i=0 observed in ISSUE, STALL or RDWAIT SHALL abort to IDLE with no pready_o and no further strobe; a strobe already issued is not undone.
REQ-014 At most one strobe per APB transfer; ctrl_wr_o and ctrl_rd_o never both 1.

Reset
REQ-015 rst_n_i=0 SHALL asynchronously force IDLE, stall counter 0, prdata_o=0, pready_o=0, pslverr_o=0, ctrl_wr_o=0, ctrl_rd_o=0, ctrl_addr_o=0, ctrl_wdata_o=0, also mid-transfer.

Configuration
REQ-016 Macro UART_APB_SLVERR_EN: defined -> pslverr_o=1 in RESP for invalid access or stall timeout; undefined -> pslverr_o tied 0, same accesses complete with pready_o, no strobe, prdata_o=0.

Verification
REQ-017 Write 0x0000_0006 to paddr 0x000 -> ctrl_wr_o pulse, ctrl_addr_o=0, ctrl_wdata_o=0x6, pready_o 2 cycles after SETUP, pslverr_o=0.
REQ-018 Read paddr 0x008, ctrl_rdata_i=0x0000_0010 -> ctrl_rd_o pulse, ctrl_addr_o=2, prdata_o=0x10 with pready_o 3 cycles after SETUP.
REQ-019 Write 0x55 to paddr 0x00C, tx_full_i=1 for 4 cycles then 0 -> single ctrl_wr_o after release, ctrl_wdata_o=0x55, pslverr_o=0.
REQ-020 Write to paddr 0x00C, tx_full_i held 1 -> no ctrl_wr_o, pready_o after STALL_MAX stall cycles, pslverr_o=1 (0 without macro).
REQ-021 Write paddr 0x010, read paddr 0x00C, read paddr 0x014, read paddr 0x002 -> no strobes, pready_o each, pslverr_o=1 with macro, 0 without.
REQ-022 rst_n_i low during STALL -> outputs zero immediately, no ctrl_wr_o after release, next transfer completes normally.

Source files
------------

// File: rtl/uart_apb_ctrl.sv
// APB slave front-end for the UART register bank: decodes, strobes and waits on the TX FIFO.
// Optional build macro UART_APB_SLVERR_EN enables pslverr_o on invalid access or TX stall timeout.
module uart_apb_ctrl #(
   parameter int ADDR_W    = 12,
   parameter int STALL_MAX = 15
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [ADDR_W-1:0] paddr_i,
   input  logic [31:0]       pwdata_i,
   output logic [31:0]       prdata_o,
   output logic              pready_o,
   output logic              pslverr_o,
   output logic              ctrl_wr_o,
   output logic              ctrl_rd_o,
   output logic [2:0]        ctrl_addr_o,
   output logic [31:0]       ctrl_wdata_o,
   input  logic [31:0]       ctrl_rdata_i,
   input  logic              tx_full_i
);

   typedef enum logic [2:0] {IDLE, ISSUE, STALL, RDWAIT, RESP} state_t;

   localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [31:0]       wdata_q;
   logic [7:0]        cnt_q;
   logic [7:0]        cnt_d;
   logic [31:0]       prdata_q;
   logic              pready_q;
   logic              wr_q;
   logic              rd_q;
   logic [2:0]        caddr_q;
   logic [31:0]       cwdata_q;

   logic [2:0]        idx;
   logic              acc_valid;
   logic              tx_block;
   logic              stall_tmo;

   // Index 3 is the write-only TX data port, index 4 the read-only RX data port.
   always_comb begin
      idx       = addr_q[4:2];
      acc_valid = (addr_q[1:0] == 2'b00) && (addr_q[ADDR_W-1:5] == '0) && (idx <= 3'd4)
                  && !(write_q && (idx == 3'd4)) && !(!write_q && (idx == 3'd3));
      tx_block  = write_q && (idx == 3'd3) && tx_full_i;
      cnt_d     = cnt_q + 8'd1;
      stall_tmo = tx_full_i && (cnt_d == STALL_LIM);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         prdata_q <= '0;
         pready_q <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         caddr_q  <= '0;
         cwdata_q <= '0;
      end else begin
         pready_q <= 1'b0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (psel_i && !penable_i) begin
                  addr_q  <= paddr_i;
                  write_q <= pwrite_i;
                  wdata_q <= pwdata_i;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (!psel_i) begin
                  state_q <= IDLE;
               end else if (!acc_valid) begin
                  prdata_q <= '0;
                  pready_q <= 1'b1;
                  state_q  <= RESP;
               end else if (tx_block) begin
                  cnt_q   <= '0;
                  state_q <= STALL;
               end else begin
                  caddr_q <= idx;
                  if (write_q) begin
                     wr_q     <= 1'b1;
                     cwdata_q <= wdata_q;
                     pready_q <= 1'b1;
                     state_q  <= RESP;
                  end else begin
                     rd_q    <= 1'b1;
                     state_q <= RDWAIT;
                  end
               end
            end
            STALL: begin
               cnt_q <= cnt_d;
               if (!psel_i) begin
                  state_q <= IDLE;
               end else if (!tx_full_i) begin
                  // Re-enter ISSUE so the FIFO level is re-checked before pushing.
                  state_q <= ISSUE;
               end else if (stall_tmo) begin
                  pready_q <= 1'b1;
                  state_q  <= RESP;
               end
            end
            RDWAIT: begin
               if (!psel_i) begin
                  state_q <= IDLE;
               end else begin
                  prdata_q <= ctrl_rdata_i;
                  pready_q <= 1'b1;
                  state_q  <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef UART_APB_SLVERR_EN
   logic err_q;
   logic err_set;

   assign err_set = psel_i && (((state_q == ISSUE) && !acc_valid) ||
                               ((state_q == STALL) && stall_tmo));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_set;
      end
   end

   assign pslverr_o = err_q;
`else
   assign pslverr_o = 1'b0;
`endif

   assign prdata_o     = prdata_q;
   assign pready_o     = pready_q;
   assign ctrl_wr_o    = wr_q;
   assign ctrl_rd_o    = rd_q;
   assign ctrl_addr_o  = caddr_q;
   assign ctrl_wdata_o = cwdata_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Scoreboard bench for uart_apb_ctrl: expected strobes/responses are queued at drive time
// and popped by monitors when the DUT produces them.
module tb_uart_apb_ctrl;

   localparam int ADDR_W    = 12;
   localparam int STALL_MAX = 15;
`ifdef UART_APB_SLVERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_n_i;
   logic              psel_i;
   logic              penable_i;
   logic              pwrite_i;
   logic [ADDR_W-1:0] paddr_i;
   logic [31:0]       pwdata_i;
   logic [31:0]       prdata_o;
   logic              pready_o;
   logic              pslverr_o;
   logic              ctrl_wr_o;
   logic              ctrl_rd_o;
   logic [2:0]        ctrl_addr_o;
   logic [31:0]       ctrl_wdata_o;
   logic [31:0]       ctrl_rdata_i;
   logic              tx_full_i;

   uart_apb_ctrl #(.ADDR_W(ADDR_W), .STALL_MAX(STALL_MAX)) dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .psel_i       (psel_i),
      .penable_i    (penable_i),
      .pwrite_i     (pwrite_i),
      .paddr_i      (paddr_i),
      .pwdata_i     (pwdata_i),
      .prdata_o     (prdata_o),
      .pready_o     (pready_o),
      .pslverr_o    (pslverr_o),
      .ctrl_wr_o    (ctrl_wr_o),
      .ctrl_rd_o    (ctrl_rd_o),
      .ctrl_addr_o  (ctrl_addr_o),
      .ctrl_wdata_o (ctrl_wdata_o),
      .ctrl_rdata_i (ctrl_rdata_i),
      .tx_full_i    (tx_full_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          setup;
   } resp_t;

   typedef struct {
      logic        wr;
      logic [2:0]  idx;
      logic [31:0] wdata;
   } strb_t;

   resp_t       resp_q[$];
   strb_t       strb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          strb_cnt = 0;
   logic [31:0] model_prdata = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Response monitor
   resp_t mon_r;
   always @(negedge clk_i) begin
      if (rst_n_i && pready_o) begin
         if (resp_q.size() == 0) begin
            check("unexp_resp", 32'(pready_o), 32'd0);
         end else begin
            mon_r = resp_q.pop_front();
            check("prdata", prdata_o, mon_r.rdata);
            check("pslverr", 32'(pslverr_o), 32'(mon_r.err));
            check("latency", 32'(cyc - mon_r.setup), 32'(mon_r.lat));
         end
      end
   end

   // Strobe monitor
   strb_t mon_s;
   always @(negedge clk_i) begin
      if (rst_n_i && ctrl_wr_o && ctrl_rd_o) check("both_strobes", 32'd1, 32'd0);
      if (rst_n_i && (ctrl_wr_o || ctrl_rd_o)) begin
         strb_cnt++;
         if (strb_q.size() == 0) begin
            check("unexp_strobe", 32'd1, 32'd0);
         end else begin
            mon_s = strb_q.pop_front();
            check("strobe_kind", 32'(ctrl_wr_o), 32'(mon_s.wr));
            check("ctrl_addr", 32'(ctrl_addr_o), 32'(mon_s.idx));
            if (mon_s.wr) check("ctrl_wdata", ctrl_wdata_o, mon_s.wdata);
         end
      end
   end

   function automatic bit acc_ok(input logic wr, input logic [ADDR_W-1:0] a);
      logic [2:0] i;
      i = a[4:2];
      return (a[1:0] == 2'b00) && (a[ADDR_W-1:5] == '0) && (i <= 3'd4) &&
             !(wr && i == 3'd4) && !(!wr && i == 3'd3);
   endfunction

   // full_hold: tx_full_i is high for this many cycles counted from the SETUP cycle.
   task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] data, input int full_hold);
      resp_t r;
      strb_t s;
      bit    valid, stall, tmo, done;
      int    n;
      valid = acc_ok(wr, addr);
      stall = wr && valid && (addr[4:2] == 3'd3) && (full_hold >= 2);
      tmo   = stall && (full_hold >= STALL_MAX + 2);
      s.wr = wr;
      s.idx = addr[4:2];
      s.wdata = data;
      if (!valid) begin
         model_prdata = '0;
         r.err = ERR_EN;
         r.lat = 2;
      end else if (!wr) begin
         model_prdata = data;
         r.err = 1'b0;
         r.lat = 3;
         strb_q.push_back(s);
      end else if (tmo) begin
         r.err = ERR_EN;
         r.lat = 2 + STALL_MAX;
      end else begin
         r.err = 1'b0;
         r.lat = stall ? full_hold + 2 : 2;
         strb_q.push_back(s);
      end
      r.rdata = model_prdata;
      r.setup = cyc;
      resp_q.push_back(r);
      psel_i = 1'b1;
      penable_i = 1'b0;
      pwrite_i = wr;
      paddr_i = addr;
      pwdata_i = wr ? data : 32'hDEAD_BEEF;
      ctrl_rdata_i = wr ? 32'h0BAD_0BAD : data;
      tx_full_i = (full_hold > 0);
      @(posedge clk_i); #1;
      penable_i = 1'b1;
      if (cyc - r.setup >= full_hold) tx_full_i = 1'b0;
      done = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk_i);
         if (pready_o) begin
            done = 1'b1;
         end else begin
            @(posedge clk_i); #1;
            if (cyc - r.setup >= full_hold) tx_full_i = 1'b0;
            n++;
         end
      end
      if (!done) check("xfer_timeout", 32'd0, 32'd1);
      @(posedge clk_i); #1;
      psel_i = 1'b0;
      penable_i = 1'b0;
      tx_full_i = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
      end
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_prdata"}, prdata_o, 32'd0);
      check({pfx, "_pready"}, 32'(pready_o), 32'd0);
      check({pfx, "_pslverr"}, 32'(pslverr_o), 32'd0);
      check({pfx, "_wr"}, 32'(ctrl_wr_o), 32'd0);
      check({pfx, "_rd"}, 32'(ctrl_rd_o), 32'd0);
      check({pfx, "_addr"}, 32'(ctrl_addr_o), 32'd0);
      check({pfx, "_wdata"}, ctrl_wdata_o, 32'd0);
   endtask

   initial begin
      int          s0;
      logic [2:0]  ri;
      logic [31:0] rd;
      rst_n_i = 1'b0;
      psel_i = 1'b0;
      penable_i = 1'b0;
      pwrite_i = 1'b0;
      paddr_i = '0;
      pwdata_i = '0;
      ctrl_rdata_i = '0;
      tx_full_i = 1'b0;
      #23;
      check_outputs_zero("rst");
      @(posedge clk_i); #3;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      apb_xfer(1'b1, 12'h000, 32'h0000_0006, 0);
      apb_xfer(1'b0, 12'h008, 32'h0000_0010, 0);
      apb_xfer(1'b1, 12'h00C, 32'h0000_0055, 5);
      apb_xfer(1'b1, 12'h00C, 32'h0000_00A1, STALL_MAX + 1);
      apb_xfer(1'b1, 12'h00C, 32'h0000_00A2, 1000);
      apb_xfer(1'b1, 12'h004, 32'h1234_5678, 3);
      apb_xfer(1'b0, 12'h004, 32'hCAFE_F00D, 0);
      apb_xfer(1'b1, 12'h010, 32'h0000_0077, 0);
      apb_xfer(1'b0, 12'h00C, 32'h1111_1111, 0);
      apb_xfer(1'b0, 12'h010, 32'h0000_00C3, 0);
      apb_xfer(1'b0, 12'h014, 32'h2222_2222, 0);
      apb_xfer(1'b0, 12'h002, 32'h3333_3333, 0);
      apb_xfer(1'b0, 12'h020, 32'h4444_4444, 0);
      apb_xfer(1'b1, 12'h100, 32'h5555_5555, 0);

      for (int k = 0; k < 8; k++) begin
         ri = 3'($urandom_range(0, 2));
         rd = $urandom;
         apb_xfer(1'($urandom_range(0, 1)), {7'd0, ri, 2'b00}, rd, 0);
      end

      // Abort: drop psel while stalled on a full TX FIFO.
      s0 = strb_cnt;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
      paddr_i = 12'h00C; pwdata_i = 32'h0000_0099; tx_full_i = 1'b1;
      idle_cycles(1);
      penable_i = 1'b1;
      idle_cycles(3);
      psel_i = 1'b0; penable_i = 1'b0;
      idle_cycles(1);
      tx_full_i = 1'b0;
      idle_cycles(5);
      check("abort_no_strobe", 32'(strb_cnt - s0), 32'd0);
      apb_xfer(1'b0, 12'h000, 32'hA5A5_0001, 0);

      // Reset asserted mid-STALL.
      s0 = strb_cnt;
      psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
      paddr_i = 12'h00C; pwdata_i = 32'h0000_0042; tx_full_i = 1'b1;
      idle_cycles(1);
      penable_i = 1'b1;
      idle_cycles(3);
      #2;
      rst_n_i = 1'b0;
      #1;
      check_outputs_zero("mid_rst");
      psel_i = 1'b0; penable_i = 1'b0;
      model_prdata = '0;
      idle_cycles(2);
      #2;
      rst_n_i = 1'b1;
      tx_full_i = 1'b0;
      idle_cycles(4);
      check("rst_no_strobe", 32'(strb_cnt - s0), 32'd0);
      apb_xfer(1'b1, 12'h00C, 32'h0000_0066, 0);
      apb_xfer(1'b0, 12'h004, 32'h0000_0081, 0);

      idle_cycles(3);
      check("sb_resp_empty", 32'(resp_q.size()), 32'd0);
      check("sb_strb_empty", 32'(strb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "bench timeout");
   end

endmodule
